// File: rtl/buffer_double_ctrl_if.sv
// buffer_double_ctrl_if: stream handshake and buffer control bundle between the
// upstream source, the double-buffered accumulator and the sequencer.
interface buffer_double_ctrl_if #(
    parameter int CWID = 10,
    parameter int WWID = 16
);
    logic            iStart;
    logic            iStop;
    logic [CWID-1:0] iLen;
    logic            iValid;
    logic            oReady;
    logic            oAccSel;
    logic            oClear;
    logic            oHold;
    logic            oDone;
    logic            oBusy;
    logic [CWID-1:0] oBeatCnt;
    logic [WWID-1:0] oWinCnt;

    modport master (
        output iStart, iStop, iLen, iValid,
        input  oReady, oAccSel, oClear, oHold, oDone, oBusy, oBeatCnt, oWinCnt
    );

    modport slave (
        input  iStart, iStop, iLen, iValid,
        output oReady, oAccSel, oClear, oHold, oDone, oBusy, oBeatCnt, oWinCnt
    );
endinterface

// File: rtl/buffer_double_ctrl.sv
// buffer_double_ctrl: sequences bank select, clear and hold of a double-buffered
// accumulator so each window sums exactly LEN beats, then swaps banks.
module buffer_double_ctrl #(
    parameter int CWID = 10,
    parameter int WWID = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    buffer_double_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CLR, ACC} state_t;

    state_t          state_q, state_d;
    logic            acc_sel_q, acc_sel_d;
    logic            done_q, done_d;
    logic            stop_q, stop_d;
    logic [CWID-1:0] beat_q, beat_d;
    logic [CWID-1:0] len_q, len_d;
    logic [WWID-1:0] win_q, win_d;
    logic            fire, last;

    // LEN=0 wraps len_q-1 to all ones, giving a full 2^CWID-beat window
    assign fire = state_q == ACC && bus.iValid;
    assign last = fire && beat_q == len_q - CWID'(1);

    always_comb begin
        state_d   = state_q == IDLE ? (bus.iStart ? CLR : IDLE) :
                    state_q == CLR  ? ACC :
                    state_q == ACC  ? (last ? ((stop_q || bus.iStop) ? IDLE : CLR) : ACC) :
                    IDLE;
        stop_d    = state_q != IDLE && !last && (stop_q || bus.iStop);
        len_d     = (state_q == IDLE && bus.iStart) ? bus.iLen : len_q;
        beat_d    = (state_q == CLR || last) ? '0 : fire ? beat_q + CWID'(1) : beat_q;
        acc_sel_d = acc_sel_q ^ last;
        win_d     = last ? win_q + WWID'(1) : win_q;
        done_d    = last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            stop_q    <= 1'b0;
            len_q     <= '0;
            beat_q    <= '0;
            acc_sel_q <= 1'b0;
            win_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            stop_q    <= stop_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            acc_sel_q <= acc_sel_d;
            win_q     <= win_d;
            done_q    <= done_d;
        end
    end

    // Hold whenever the active bank must not change: only CLR and a transferred beat write it
    assign bus.oReady   = state_q == ACC;
    assign bus.oClear   = state_q == CLR;
    assign bus.oHold    = !(state_q == CLR || fire);
    assign bus.oBusy    = state_q != IDLE;
    assign bus.oAccSel  = acc_sel_q;
    assign bus.oDone    = done_q;
    assign bus.oBeatCnt = beat_q;
    assign bus.oWinCnt  = win_q;
endmodule

// File: tb/tb_buffer_double_ctrl.sv
// tb_buffer_double_ctrl: directed checks of the double-buffer sequencer driving
// a behavioural two-bank accumulator.
module tb_buffer_double_ctrl;
    localparam int CWID = 4;
    localparam int WWID = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data = '0;
    logic [15:0] bank [2];
    logic [15:0] buf_out;
    int n_chk = 0;
    int n_fail = 0;

    buffer_double_ctrl_if #(.CWID(CWID), .WWID(WWID)) bus ();

    buffer_double_ctrl #(.CWID(CWID), .WWID(WWID)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Accumulator buffer: active bank written unless held, other bank is the output
    always @(posedge clk)
        if (!bus.oHold) bank[bus.oAccSel] <= bus.oClear ? 16'd0 : bank[bus.oAccSel] + 16'(data);
    assign buf_out = bank[~bus.oAccSel];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_accsel"}, bus.oAccSel, 0);
        chk({tag, "_clear"}, bus.oClear, 0);
        chk({tag, "_hold"}, bus.oHold, 1);
        chk({tag, "_ready"}, bus.oReady, 0);
        chk({tag, "_done"}, bus.oDone, 0);
        chk({tag, "_busy"}, bus.oBusy, 0);
        chk({tag, "_beat"}, bus.oBeatCnt, 0);
        chk({tag, "_win"}, bus.oWinCnt, 0);
    endtask

    initial begin
        bus.iStart = 0; bus.iStop = 0; bus.iLen = '0; bus.iValid = 0;
        #2;
        chk_reset("rst");
        tick;
        rst_n = 1;

        // Window of 4 with a stop mid-window and an ignored iStart while busy
        bus.iStart = 1; bus.iLen = 4; bus.iValid = 1; data = 1;
        tick;
        bus.iStart = 0; #1;
        chk("t1_clr_clear", bus.oClear, 1);
        chk("t1_clr_ready", bus.oReady, 0);
        chk("t1_clr_hold", bus.oHold, 0);
        chk("t1_clr_busy", bus.oBusy, 1);
        tick;
        bus.iStart = 1; bus.iLen = 7; #1;
        chk("t1_acc_ready", bus.oReady, 1);
        chk("t1_acc_hold", bus.oHold, 0);
        chk("t1_beat0", bus.oBeatCnt, 0);
        tick;
        bus.iStart = 0; bus.iStop = 1; #1;
        chk("t1_beat1", bus.oBeatCnt, 1);
        tick;
        bus.iStop = 0; #1;
        chk("t1_beat2", bus.oBeatCnt, 2);
        tick;
        chk("t1_beat3", bus.oBeatCnt, 3);
        chk("t1_nodone", bus.oDone, 0);
        tick;
        chk("t1_done", bus.oDone, 1);
        chk("t1_accsel", bus.oAccSel, 1);
        chk("t1_win", bus.oWinCnt, 1);
        chk("t1_beat_clr", bus.oBeatCnt, 0);
        chk("t1_idle_busy", bus.oBusy, 0);
        chk("t1_idle_hold", bus.oHold, 1);
        chk("t1_sum", buf_out, 4);
        tick;
        chk("t1_done_pulse", bus.oDone, 0);
        chk("t1_sum_stable", buf_out, 4);
        chk("t1_still_idle", bus.oBusy, 0);

        // Toggling valid; stop arrives with the last beat
        bus.iStart = 1; bus.iLen = 4; bus.iValid = 0;
        tick;
        bus.iStart = 0;
        tick;
        for (int k = 0; k < 7; k++) begin
            bus.iValid = (k % 2 == 0);
            bus.iStop = (k == 6);
            #1;
            if (k % 2 == 1) chk("t2_hold_idle", bus.oHold, 1);
            chk("t2_nodone", bus.oDone, 0);
            if (k == 6) chk("t2_beat3", bus.oBeatCnt, 3);
            tick;
        end
        bus.iStop = 0; bus.iValid = 0; #1;
        chk("t2_done", bus.oDone, 1);
        chk("t2_accsel", bus.oAccSel, 0);
        chk("t2_win", bus.oWinCnt, 2);
        chk("t2_busy", bus.oBusy, 0);
        chk("t2_sum", buf_out, 4);
        tick;
        chk("t2_done_pulse", bus.oDone, 0);
        chk("t2_no_clr", bus.oClear, 0);

        // Back-to-back windows of 3, stop during the second; window count wraps
        bus.iStart = 1; bus.iLen = 3; bus.iValid = 1; data = 2;
        tick;
        bus.iStart = 0;
        tick; tick; tick; tick;
        chk("t3_done1", bus.oDone, 1);
        chk("t3_accsel1", bus.oAccSel, 1);
        chk("t3_win1", bus.oWinCnt, 3);
        chk("t3_sum1", buf_out, 6);
        chk("t3_bubble", bus.oClear, 1);
        chk("t3_bubble_ready", bus.oReady, 0);
        tick;
        bus.iStop = 1;
        chk("t3_w2_beat0", bus.oBeatCnt, 0);
        tick;
        bus.iStop = 0;
        tick; tick;
        chk("t3_done2", bus.oDone, 1);
        chk("t3_accsel2", bus.oAccSel, 0);
        chk("t3_win_wrap", bus.oWinCnt, 0);
        chk("t3_sum2", buf_out, 6);
        chk("t3_busy", bus.oBusy, 0);
        tick;
        chk("t3_no_clr", bus.oClear, 0);
        chk("t3_idle", bus.oBusy, 0);
        chk("t3_done_pulse", bus.oDone, 0);

        // LEN=0 spans 2^CWID beats
        bus.iStart = 1; bus.iLen = 0; bus.iValid = 1; data = 1;
        tick;
        bus.iStart = 0;
        tick;
        for (int i = 0; i < 15; i++) begin
            chk("t4_beat", bus.oBeatCnt, i);
            tick;
        end
        bus.iStop = 1;
        chk("t4_beat15", bus.oBeatCnt, 15);
        chk("t4_nodone", bus.oDone, 0);
        tick;
        bus.iStop = 0;
        chk("t4_wrap", bus.oBeatCnt, 0);
        chk("t4_done", bus.oDone, 1);
        chk("t4_accsel", bus.oAccSel, 1);
        chk("t4_win", bus.oWinCnt, 1);
        chk("t4_sum", buf_out, 16);
        chk("t4_idle", bus.oBusy, 0);

        // Reset mid-window, then start+stop together runs two windows
        bus.iStart = 1; bus.iLen = 4; bus.iValid = 1; data = 1;
        tick;
        bus.iStart = 0;
        tick; tick; tick;
        chk("t5_beat2", bus.oBeatCnt, 2);
        rst_n = 0; #1;
        chk_reset("t5_rst");
        tick;
        chk("t5_rst_nodone", bus.oDone, 0);
        rst_n = 1;
        bus.iStart = 1; bus.iStop = 1; bus.iLen = 2; data = 3;
        tick;
        bus.iStart = 0; bus.iStop = 0;
        tick; tick;
        chk("t5_nodone", bus.oDone, 0);
        tick;
        chk("t5_done1", bus.oDone, 1);
        chk("t5_accsel1", bus.oAccSel, 1);
        chk("t5_win1", bus.oWinCnt, 1);
        chk("t5_sum1", buf_out, 6);
        chk("t5_continue", bus.oClear, 1);
        bus.iStop = 1;
        tick;
        bus.iStop = 0;
        tick; tick;
        chk("t5_done2", bus.oDone, 1);
        chk("t5_accsel2", bus.oAccSel, 0);
        chk("t5_win2", bus.oWinCnt, 2);
        chk("t5_sum2", buf_out, 6);
        chk("t5_idle", bus.oBusy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
